// File: rtl/huffman_stage_ctrl.sv
// Sequencer for the Huffman pipeline (count -> sort -> tree -> code): launches each
// stage in turn, waits for its done pulse under a watchdog, and flags the finished code table.
module huffman_stage_ctrl #(
    parameter int N_STAGES = 4,
    parameter int TIMER_W  = 8,
    parameter int TIMEOUT  = 200
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_clear,
    input  logic [N_STAGES-1:0] i_stage_done,
    output logic [N_STAGES-1:0] o_stage_start,
    output logic [N_STAGES-1:0] o_stage_en,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_code_valid,
    output logic                o_error,
    output logic [1:0]          o_err_stage,
    output logic [7:0]          o_run_cnt,
    output logic [1:0]          o_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_stage;
    logic [TIMER_W-1:0]   r_timer;
    logic [N_STAGES-1:0]  r_stage_start;
    logic [N_STAGES-1:0]  r_stage_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_code_valid;
    logic                 r_error;
    logic [1:0]           r_err_stage;
    logic [7:0]           r_run_cnt;

    logic                 w_done_hit;
    logic                 w_last;
    logic                 w_timeout;
    logic [N_STAGES-1:0]  w_next_onehot;

    // Stage handshake: the controller pulses STAGE_START for one cycle and holds
    // STAGE_EN while the stage works; the stage answers with a one-cycle STAGE_DONE,
    // which only counts in WAIT and only on the bit of the active stage.
    always_comb begin
        w_done_hit    = i_stage_done[r_stage];
        w_last        = (r_stage == 2'(N_STAGES - 1));
        w_timeout     = (r_timer == TIMER_W'(TIMEOUT - 1));
        w_next_onehot = N_STAGES'(1) << (r_stage + 2'd1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_stage       <= '0;
            r_timer       <= '0;
            r_stage_start <= '0;
            r_stage_en    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_code_valid  <= 1'b0;
            r_error       <= 1'b0;
            r_err_stage   <= '0;
            r_run_cnt     <= '0;
        end else begin
            r_stage_start <= '0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_state       <= S_LAUNCH;
                        r_stage       <= '0;
                        r_code_valid  <= 1'b0;
                        r_stage_start <= N_STAGES'(1);
                        r_stage_en    <= N_STAGES'(1);
                        r_busy        <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (i_abort) begin
                        r_state    <= S_IDLE;
                        r_stage_en <= '0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end
                end
                S_WAIT: begin
                    // Abort beats done, and done beats the watchdog.
                    if (i_abort) begin
                        r_state    <= S_IDLE;
                        r_stage_en <= '0;
                        r_busy     <= 1'b0;
                    end else if (w_done_hit) begin
                        if (!w_last) begin
                            r_state       <= S_LAUNCH;
                            r_stage       <= r_stage + 2'd1;
                            r_stage_start <= w_next_onehot;
                            r_stage_en    <= w_next_onehot;
                        end else begin
                            r_state      <= S_IDLE;
                            r_done       <= 1'b1;
                            r_code_valid <= 1'b1;
                            r_run_cnt    <= r_run_cnt + 8'd1;
                            r_stage_en   <= '0;
                            r_busy       <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state     <= S_FAULT;
                        r_error     <= 1'b1;
                        r_err_stage <= r_stage;
                        r_stage_en  <= '0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (i_clear) begin
                        r_state <= S_IDLE;
                        r_error <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stage_start = r_stage_start;
    assign o_stage_en    = r_stage_en;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_code_valid  = r_code_valid;
    assign o_error       = r_error;
    assign o_err_stage   = r_err_stage;
    assign o_run_cnt     = r_run_cnt;
    assign o_state       = r_state;

endmodule

// File: tb/tb_huffman_stage_ctrl.sv
// Bench for huffman_stage_ctrl: directed scenarios plus randomized runs, checked
// cycle by cycle against a run-level model of the sequencer.
module tb_huffman_stage_ctrl;

    localparam int N   = 4;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sdone = 4'b0;
    logic [3:0] o_stage_start;
    logic [3:0] o_stage_en;
    logic       o_busy;
    logic       o_done;
    logic       o_code_valid;
    logic       o_error;
    logic [1:0] o_err_stage;
    logic [7:0] o_run_cnt;
    logic [1:0] o_state;

    always #5 clk = ~clk;

    huffman_stage_ctrl #(.N_STAGES(N), .TIMER_W(8), .TIMEOUT(TMO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .i_clear       (clear),
        .i_stage_done  (sdone),
        .o_stage_start (o_stage_start),
        .o_stage_en    (o_stage_en),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_code_valid  (o_code_valid),
        .o_error       (o_error),
        .o_err_stage   (o_err_stage),
        .o_run_cnt     (o_run_cnt),
        .o_state       (o_state)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    // Model of the architecturally visible state
    logic [7:0] m_cnt = 8'd0;
    logic       m_cv  = 1'b0;
    logic [1:0] m_err_stage = 2'd0;
    logic [7:0] exp_q[$];
    int         dly[4];
    int         outcome;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int s);
        return 4'b0001 << s;
    endfunction

    task automatic chk_outs(input string tag, input logic [3:0] e_start, input logic [3:0] e_en,
                            input logic e_busy, input logic e_done, input logic e_err);
        chk({tag, ".stage_start"}, 32'(o_stage_start), 32'(e_start));
        chk({tag, ".stage_en"},    32'(o_stage_en),    32'(e_en));
        chk({tag, ".busy"},        32'(o_busy),        32'(e_busy));
        chk({tag, ".done"},        32'(o_done),        32'(e_done));
        chk({tag, ".error"},       32'(o_error),       32'(e_err));
        chk({tag, ".code_valid"},  32'(o_code_valid),  32'(m_cv));
        chk({tag, ".run_cnt"},     32'(o_run_cnt),     32'(m_cnt));
        chk({tag, ".err_stage"},   32'(o_err_stage),   32'(m_err_stage));
    endtask

    // One run from IDLE. Stage s gets its done pulse dly[s] cycles into WAIT
    // (dly >= TMO means never). kill: 1 = abort, 2 = async reset, at WAIT cycle kw of stage ks.
    // outcome: 0 completed, 1 aborted, 2 reset, 3 fault.
    task automatic run(input int kill, input int ks, input int kw, input bit noisy,
                       output int res);
        int cycles;
        int exp_lat;
        start = 1'b1;
        step();
        start = 1'b0;
        m_cv = 1'b0;
        cycles = 0;
        exp_lat = 0;
        for (int s = 0; s < N; s++) begin
            exp_lat += dly[s] + 2;
            chk_outs("launch", oh(s), oh(s), 1'b1, 1'b0, 1'b0);
            if (noisy) begin
                sdone = 4'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            step();
            cycles++;
            sdone = 4'b0;
            start = 1'b0;
            for (int w = 0; w < TMO; w++) begin
                chk_outs("wait", 4'b0, oh(s), 1'b1, 1'b0, 1'b0);
                if (kill == 1 && s == ks && w == kw) begin
                    abort = 1'b1;
                    sdone = 4'($urandom) | oh(s);
                    start = 1'($urandom_range(0, 1));
                    step();
                    abort = 1'b0;
                    sdone = 4'b0;
                    start = 1'b0;
                    chk_outs("abort", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
                    res = 1;
                    return;
                end
                if (kill == 2 && s == ks && w == kw) begin
                    #2 rst_n = 1'b0;
                    #1;
                    m_cnt = 8'd0;
                    m_cv = 1'b0;
                    m_err_stage = 2'd0;
                    chk_outs("async_rst", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
                    res = 2;
                    return;
                end
                if (w == dly[s]) begin
                    sdone = oh(s) | (noisy ? 4'($urandom) : 4'b0);
                    start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                    step();
                    cycles++;
                    sdone = 4'b0;
                    start = 1'b0;
                    break;
                end
                if (w == TMO - 1) begin
                    step();
                    m_err_stage = 2'(s);
                    chk_outs("fault", 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
                    res = 3;
                    return;
                end
                if (noisy) begin
                    sdone = 4'($urandom) & ~oh(s);
                    start = 1'($urandom_range(0, 1));
                end
                step();
                cycles++;
                sdone = 4'b0;
                start = 1'b0;
            end
        end
        m_cnt = m_cnt + 8'd1;
        m_cv = 1'b1;
        chk_outs("done", 4'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        chk("latency", 32'(cycles), 32'(exp_lat));
        res = 0;
    endtask

    initial begin
        // Reset
        step();
        step();
        chk_outs("reset", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.state", 32'(o_state), 32'd0);
        rst_n = 1'b1;
        step();

        // Normal run, done 3 cycles into each WAIT
        dly = '{3, 3, 3, 3};
        run(0, 0, 0, 1'b0, outcome);
        chk("normal.outcome", 32'(outcome), 32'd0);
        step();
        chk_outs("normal.after", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        // Minimum run: 2*N cycles from START to DONE
        dly = '{0, 0, 0, 0};
        run(0, 0, 0, 1'b0, outcome);
        chk("minrun.outcome", 32'(outcome), 32'd0);
        chk("minrun.latency", 32'(dly[0] + dly[1] + dly[2] + dly[3] + 2 * N), 32'd8);

        // Timeout on stage 2, then START/ABORT ignored in FAULT, CLEAR leaves it
        dly = '{1, 2, TMO + 10, 0};
        run(0, 0, 0, 1'b0, outcome);
        chk("timeout.outcome", 32'(outcome), 32'd3);
        chk("timeout.err_stage", 32'(o_err_stage), 32'd2);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            abort = 1'($urandom_range(0, 1));
            step();
            chk_outs("fault.hold", 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        end
        start = 1'b0;
        abort = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_outs("clear", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        // Stray done bits plus done on the last allowed WAIT cycle
        dly = '{0, 4, TMO - 1, 2};
        run(0, 0, 0, 1'b1, outcome);
        chk("boundary.outcome", 32'(outcome), 32'd0);

        // Abort during stage-1 WAIT, then ABORT+START together in IDLE
        dly = '{1, 5, 1, 1};
        run(1, 1, 2, 1'b0, outcome);
        chk("abort.outcome", 32'(outcome), 32'd1);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk_outs("abort_start_idle", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk_outs("abort_start_idle2", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        // Async reset during stage-2 WAIT, then a fresh run starts at stage 0
        dly = '{1, 1, 6, 1};
        run(2, 2, 3, 1'b0, outcome);
        chk("arst.outcome", 32'(outcome), 32'd2);
        step();
        chk_outs("arst.held", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        dly = '{1, 1, 1, 1};
        exp_q.push_back(m_cnt + 8'd1);
        run(0, 0, 0, 1'b0, outcome);
        chk("arst.rerun", 32'(outcome), 32'd0);
        chk("sb.rerun", 32'(o_run_cnt), 32'(exp_q.pop_front()));

        // Back-to-back randomized runs; 256 completed runs since reset wrap the counter
        for (int r = 0; r < 255; r++) begin
            for (int s = 0; s < N; s++) dly[s] = $urandom_range(0, 3);
            exp_q.push_back(m_cnt + 8'd1);
            run(0, 0, 0, 1'b1, outcome);
            chk("b2b.outcome", 32'(outcome), 32'd0);
            chk("sb.b2b", 32'(o_run_cnt), 32'(exp_q.pop_front()));
        end
        chk("wrap.run_cnt", 32'(o_run_cnt), 32'd0);
        step();
        chk_outs("final.idle", 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
